// File: rtl/seg_display_pkg.sv
// Shared definitions for the 7-segment display controller: register map,
// CTRL bit positions, reset values and the segment decode table.
package seg_display_pkg;

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_CTRL   = 2'd1,
      REG_BRIGHT = 2'd2,
      REG_STATUS = 2'd3
   } reg_off_e;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_CFORCE = 1;
   localparam int CTRL_CBLINK = 2;
   localparam int CTRL_BLANK  = 4;

   // Bit 3 of CTRL is reserved and always reads back as 0.
   localparam logic [7:0] CTRL_WMASK = 8'hF7;

   localparam logic [15:0] RST_DATA   = 16'h0000;
   localparam logic [7:0]  RST_CTRL   = 8'h01;
   localparam logic [3:0]  RST_BRIGHT = 4'hF;

   typedef struct packed {
      logic [15:0] data;
      logic [7:0]  ctrl;
      logic [3:0]  bright;
   } disp_regs_t;

   localparam disp_regs_t RST_REGS = '{data: RST_DATA, ctrl: RST_CTRL, bright: RST_BRIGHT};

   typedef logic [6:0] seg_t;

   // Panel is mounted upside down, so a/d, b/e and c/f are swapped.
   localparam seg_t [0:15] SEG_LUT = '{
      7'h3F, 7'h30, 7'h5B, 7'h79, 7'h74, 7'h6D, 7'h6F, 7'h38,
      7'h7F, 7'h7D, 7'h7E, 7'h67, 7'h0F, 7'h73, 7'h4F, 7'h4E
   };

endpackage

// File: rtl/seg_display_ctrl_seg_scan_timer.sv
// Digit scan timing: slot counter, digit index, frame-end strobe and the
// brightness on-window for the current slot.
module seg_scan_timer #(
   parameter int SLOT_CYCLES = 4000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [3:0] bright_i,
   output logic [1:0] digit_o,
   output logic       frame_end_o,
   output logic       on_win_o
);

   localparam int CW = $clog2(SLOT_CYCLES);
   localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
   localparam int STEP = SLOT_CYCLES / 16;

   logic [CW-1:0] slot_q, slot_d;
   logic [1:0]    digit_q, digit_d;
   logic          slot_wrap;
   logic [31:0]   thresh;

   assign slot_wrap = (slot_q == SLOT_LAST);

   always_comb begin
      slot_d  = slot_wrap ? '0 : slot_q + 1'b1;
      digit_d = slot_wrap ? digit_q + 1'b1 : digit_q;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         slot_q  <= '0;
         digit_q <= '0;
      end else begin
         slot_q  <= slot_d;
         digit_q <= digit_d;
      end
   end

   // Slot 0 is always dark so the commons settle before new segments show.
   assign thresh      = (32'(bright_i) + 32'd1) * 32'(STEP);
   assign on_win_o    = (slot_q != '0) && (32'(slot_q) < thresh);
   assign digit_o     = digit_q;
   assign frame_end_o = slot_wrap && (digit_q == 2'd3);

endmodule

// File: rtl/seg_display_ctrl.sv
// iomem slave driving a 4-digit multiplexed 7-segment display with colon.
// Register writes land in staging and reach the display only at frame ends.
module seg_display_ctrl
   import seg_display_pkg::*;
#(
   parameter logic [7:0] BASE         = 8'h04,
   parameter int         SLOT_CYCLES  = 4000,
   parameter int         BLINK_CYCLES = 8_000_000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic [3:0]  comm,
   output logic [6:0]  seg,
   output logic        colon
);

   localparam int BW = $clog2(BLINK_CYCLES);

   disp_regs_t  stg_q, stg_d, act_q;
   logic        pending_q, pending_d;
   logic        ready_q;
   logic [31:0] rdata_q, rd_mux;
   logic [BW-1:0] blink_q;
   logic        phase_q;
   logic [3:0]  comm_q;
   logic [6:0]  seg_q;
   logic        colon_q;

   logic        accept, wr_en, rd_en, boundary;
   logic        frame_end, on_win, digit_on;
   logic [1:0]  digit;
   logic [3:0]  nibble, blank;
   reg_off_e    reg_sel;
   logic        unused_bits;

   assign accept   = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE);
   assign wr_en    = accept && (iomem_wstrb != 4'b0000);
   assign rd_en    = accept && (iomem_wstrb == 4'b0000);
   assign reg_sel  = reg_off_e'(iomem_addr[3:2]);
   // A disabled display has nothing to tear, so apply staging immediately.
   assign boundary = frame_end || !act_q.ctrl[CTRL_EN];

   seg_scan_timer #(.SLOT_CYCLES(SLOT_CYCLES)) u_scan (
      .clk         (clk),
      .resetn      (resetn),
      .bright_i    (act_q.bright),
      .digit_o     (digit),
      .frame_end_o (frame_end),
      .on_win_o    (on_win)
   );

   always_comb begin
      stg_d     = stg_q;
      pending_d = boundary ? 1'b0 : pending_q;
      if (wr_en) begin
         case (reg_sel)
            REG_DATA: begin
               if (iomem_wstrb[0]) stg_d.data[7:0]  = iomem_wdata[7:0];
               if (iomem_wstrb[1]) stg_d.data[15:8] = iomem_wdata[15:8];
               pending_d = 1'b1;
            end
            REG_CTRL: begin
               if (iomem_wstrb[0]) stg_d.ctrl = iomem_wdata[7:0] & CTRL_WMASK;
               pending_d = 1'b1;
            end
            REG_BRIGHT: begin
               if (iomem_wstrb[0]) stg_d.bright = iomem_wdata[3:0];
               pending_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         REG_DATA:   rd_mux[15:0] = stg_q.data;
         REG_CTRL:   rd_mux[7:0]  = stg_q.ctrl;
         REG_BRIGHT: rd_mux[3:0]  = stg_q.bright;
         default:    rd_mux[3:0]  = {phase_q, pending_q, digit};
      endcase
   end

   assign blank    = act_q.ctrl[7:4];
   assign nibble   = act_q.data[{~digit, 2'b00} +: 4];
   assign digit_on = act_q.ctrl[CTRL_EN] && !blank[digit] && on_win;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         stg_q     <= RST_REGS;
         act_q     <= RST_REGS;
         pending_q <= 1'b0;
         ready_q   <= 1'b0;
         rdata_q   <= '0;
         blink_q   <= '0;
         phase_q   <= 1'b1;
         comm_q    <= 4'hF;
         seg_q     <= '0;
         colon_q   <= 1'b0;
      end else begin
         stg_q     <= stg_d;
         pending_q <= pending_d;
         if (boundary) act_q <= stg_q;
         ready_q   <= accept;
         rdata_q   <= rd_en ? rd_mux : '0;
         if (blink_q == BW'(BLINK_CYCLES - 1)) begin
            blink_q <= '0;
            phase_q <= ~phase_q;
         end else begin
            blink_q <= blink_q + 1'b1;
         end
         comm_q  <= digit_on ? ~(4'b0001 << digit) : 4'hF;
         seg_q   <= digit_on ? SEG_LUT[nibble] : 7'h00;
         colon_q <= act_q.ctrl[CTRL_EN] &&
                    (act_q.ctrl[CTRL_CFORCE] || (act_q.ctrl[CTRL_CBLINK] && phase_q));
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign comm        = comm_q;
   assign seg         = seg_q;
   assign colon       = colon_q;

   assign unused_bits = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:16], act_q.ctrl[3]};

endmodule
